issue_unit: RTL and testbench

Single-issue scheduler that sits between the four issue queues (integer, multiply, divide, load/store) and the shared common data bus (CDB). Each cycle it grants at most one ready queue, using a round-robin arbiter. A grant is only given if the CDB slot in which that unit's result will appear is still free. It keeps a CDB reservation shift register and a divider-busy counter, and each cycle it tells the CDB mux which unit owns the bus.

---
 rtl/issue_unit.sv | 105 ++++++++++
 tb/tb_issue_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// Round-robin single-issue scheduler for int/mul/div/ls queues onto the shared CDB.
// Latency: grants are combinational; a grant in cycle t owns the CDB in cycle t+L.
// Backpressure: a ready queue is held off while its CDB slot is reserved, or while the divider is busy.
module issue_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issueint_ready,
    input  logic       issuemul_ready,
    input  logic       issuediv_ready,
    input  logic       issuels_ready,
    output logic       issueint_done,
    output logic       issuemul_done,
    output logic       issuediv_done,
    output logic       issuels_done,
    output logic [1:0] cdb_owner,
    output logic       cdb_owner_valid
);

    localparam logic [1:0] U_MUL = 2'd1;
    localparam logic [1:0] U_DIV = 2'd2;

    // Entry i holds the CDB owner i cycles from now; entry 0 is the current bus owner.
    logic [DIV_LAT:0]      res_vld;
    logic [DIV_LAT:0][1:0] res_own;
    logic [1:0]            rr_ptr;
    logic [3:0]            div_cnt;

    logic [3:0] rdy;
    logic [3:0] elig;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic [3:0] gnt_slot;

    assign rdy = {issuels_ready, issuediv_ready, issuemul_ready, issueint_ready};

    // A unit may issue only if the slot its result lands in is still free.
    assign elig[0] = rdy[0] && !res_vld[1];
    assign elig[1] = rdy[1] && !res_vld[MUL_LAT];
    assign elig[2] = rdy[2] && !res_vld[DIV_LAT] && (div_cnt == 4'd0);
    assign elig[3] = rdy[3] && !res_vld[1];

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!gnt_vld && elig[2'(rr_ptr + 2'(i))]) begin
                gnt_vld = 1'b1;
                gnt_id  = 2'(rr_ptr + 2'(i));
            end
        end
    end

    always_comb begin
        gnt_slot = 4'd0;
        case (gnt_id)
            U_MUL:   gnt_slot = 4'(MUL_LAT - 1);
            U_DIV:   gnt_slot = 4'(DIV_LAT - 1);
            default: gnt_slot = 4'd0;
        endcase
    end

    assign gnt           = gnt_vld ? (4'b0001 << gnt_id) : 4'b0000;
    assign issueint_done = gnt[0];
    assign issuemul_done = gnt[1];
    assign issuediv_done = gnt[2];
    assign issuels_done  = gnt[3];

    assign cdb_owner       = res_own[0];
    assign cdb_owner_valid = res_vld[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_vld <= '0;
            res_own <= '0;
            rr_ptr  <= 2'd0;
            div_cnt <= 4'd0;
        end else begin
            // The granted slot is known empty after the shift, so it simply overrides.
            for (int i = 0; i < DIV_LAT; i++) begin
                if (gnt_vld && gnt_slot == 4'(i)) begin
                    res_vld[i] <= 1'b1;
                    res_own[i] <= gnt_id;
                end else begin
                    res_vld[i] <= res_vld[i+1];
                    res_own[i] <= res_own[i+1];
                end
            end
            res_vld[DIV_LAT] <= 1'b0;
            res_own[DIV_LAT] <= 2'd0;

            if (gnt_vld)
                rr_ptr <= gnt_id + 2'd1;

            if (gnt_vld && gnt_id == U_DIV)
                div_cnt <= 4'(DIV_LAT - 1);
            else if (div_cnt != 4'd0)
                div_cnt <= div_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios on the default build, random stress on three latency builds.
module tb_issue_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rdy0 = '0, rdy1 = '0, rdy2 = '0;
    logic [3:0] dn0, dn1, dn2;
    logic [1:0] own0, own1, own2;
    logic       ov0, ov1, ov2;

    issue_unit #(.MUL_LAT(2), .DIV_LAT(2)) d0 (
        .clk(clk), .reset_n(reset_n),
        .issueint_ready(rdy0[0]), .issuemul_ready(rdy0[1]),
        .issuediv_ready(rdy0[2]), .issuels_ready(rdy0[3]),
        .issueint_done(dn0[0]), .issuemul_done(dn0[1]),
        .issuediv_done(dn0[2]), .issuels_done(dn0[3]),
        .cdb_owner(own0), .cdb_owner_valid(ov0)
    );

    issue_unit #(.MUL_LAT(4), .DIV_LAT(7)) d1 (
        .clk(clk), .reset_n(reset_n),
        .issueint_ready(rdy1[0]), .issuemul_ready(rdy1[1]),
        .issuediv_ready(rdy1[2]), .issuels_ready(rdy1[3]),
        .issueint_done(dn1[0]), .issuemul_done(dn1[1]),
        .issuediv_done(dn1[2]), .issuels_done(dn1[3]),
        .cdb_owner(own1), .cdb_owner_valid(ov1)
    );

    issue_unit #(.MUL_LAT(15), .DIV_LAT(15)) d2 (
        .clk(clk), .reset_n(reset_n),
        .issueint_ready(rdy2[0]), .issuemul_ready(rdy2[1]),
        .issuediv_ready(rdy2[2]), .issuels_ready(rdy2[3]),
        .issueint_done(dn2[0]), .issuemul_done(dn2[1]),
        .issuediv_done(dn2[2]), .issuels_done(dn2[3]),
        .cdb_owner(own2), .cdb_owner_valid(ov2)
    );

    typedef struct {
        int         dut;
        int         due;
        logic [1:0] own;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [3:0] smp_done[3];
    logic [3:0] smp_rdy[3];
    logic [1:0] smp_own[3];
    logic       smp_ov[3];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int lat(input int dut, input int unit);
        int ml, dl;
        ml = (dut == 0) ? 2 : (dut == 1) ? 4 : 15;
        dl = (dut == 0) ? 2 : (dut == 1) ? 7 : 15;
        case (unit)
            1:       return ml;
            2:       return dl;
            default: return 1;
        endcase
    endfunction

    // Samples the current cycle, scores it, then advances to the next negedge.
    task automatic tick();
        int idx[$];
        #1;
        smp_done[0] = dn0; smp_done[1] = dn1; smp_done[2] = dn2;
        smp_rdy[0]  = rdy0; smp_rdy[1] = rdy1; smp_rdy[2] = rdy2;
        smp_own[0]  = own0; smp_own[1] = own1; smp_own[2] = own2;
        smp_ov[0]   = ov0;  smp_ov[1]  = ov1;  smp_ov[2]  = ov2;
        for (int j = 0; j < 3; j++) begin
            idx = sbq.find_first_index(e) with (e.dut == j && e.due == cyc);
            if (smp_ov[j]) begin
                check("sb_owner_expected", idx.size(), 1);
                if (idx.size() > 0) begin
                    check("sb_owner_id", int'(smp_own[j]), int'(sbq[idx[0]].own));
                    sbq.delete(idx[0]);
                end
            end else begin
                check("sb_owner_missing", idx.size(), 0);
                if (idx.size() > 0) sbq.delete(idx[0]);
            end
            check("onehot_done", $countones(smp_done[j]) <= 1, 1);
            check("done_without_ready", int'(smp_done[j] & ~smp_rdy[j]), 0);
            for (int u = 0; u < 4; u++) begin
                if (smp_done[j][u]) sbq.push_back('{dut: j, due: cyc + lat(j, u), own: 2'(u)});
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rdy0 = '0; rdy1 = '0; rdy2 = '0;
        #1;
        check("rst_ov0", ov0, 0);
        check("rst_ov1", ov1, 0);
        check("rst_ov2", ov2, 0);
        check("rst_own1", int'(own1), 0);
        sbq.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_g;
        @(negedge clk);
        do_reset();

        // Round robin over int, mul, ls with div idle
        rdy1 = 4'b1011;
        for (int k = 0; k < 15; k++) begin
            tick();
            exp_g = (k % 3 == 0) ? 1 : (k % 3 == 1) ? 2 : 8;
            check("rr_grant", int'(smp_done[1]), exp_g);
        end

        // Reset with reservations in flight, then idle
        do_reset();
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_done", int'(smp_done[1]), 0);
            check("idle_ov", smp_ov[1], 0);
        end
        rdy1 = 4'b0001;
        tick();
        check("post_rst_grant", int'(smp_done[1]), 1);
        rdy1 = 4'b0000;
        tick();
        check("post_rst_ov", smp_ov[1], 1);
        check("post_rst_own", int'(smp_own[1]), 0);

        // CDB collision: mul at rel 0, int ready from rel 1
        do_reset();
        rdy1 = 4'b0010;
        tick();
        check("col_mul_grant", int'(smp_done[1]), 2);
        for (int k = 1; k <= 5; k++) begin
            rdy1 = (k <= 4) ? 4'b0001 : 4'b0000;
            tick();
            check("col_int_grant", int'(smp_done[1]), (k == 3 || k == 5) ? 0 : 1);
            if (k >= 2) begin
                check("col_ov", smp_ov[1], 1);
                check("col_own", int'(smp_own[1]), (k == 4) ? 1 : 0);
            end
        end

        // Divider occupancy
        do_reset();
        rdy1 = 4'b0100;
        for (int k = 0; k < 22; k++) begin
            tick();
            check("div_grant", smp_done[1][2], (k % 7 == 0) ? 1 : 0);
            check("div_owner", (smp_ov[1] && smp_own[1] == 2'd2) ? 1 : 0,
                  (k % 7 == 0 && k > 0) ? 1 : 0);
        end

        // Random stress on all three builds, then drain
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rdy0 = 4'($urandom_range(0, 15));
            rdy1 = 4'($urandom_range(0, 15));
            rdy2 = 4'($urandom_range(0, 15));
            tick();
        end
        rdy0 = '0; rdy1 = '0; rdy2 = '0;
        for (int k = 0; k < 20; k++) tick();
        check("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
